// File: rtl/debug_pkg.sv
// Shared definitions for the pipeline debug controller: command bytes,
// controller states and a small state-classification helper.
package debug_pkg;

  // Command bytes received over the UART.
  localparam logic [7:0] CMD_RUN    = 8'h63;  // 'c'
  localparam logic [7:0] CMD_STEP   = 8'h73;  // 's'
  localparam logic [7:0] CMD_PRESET = 8'h72;  // 'r'

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_STEP    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_SEND    = 3'd4,
    ST_PRESET  = 3'd5
  } state_e;

  // States in which the pipeline registers are clocked.
  function automatic logic enables_pipe(state_e s);
    return (s == ST_RUN) || (s == ST_STEP);
  endfunction

endpackage

// File: rtl/debug_byte_serializer.sv
// Shadow register plus byte serializer: latches the snapshot and the cycle
// counter, then streams them to the TX FIFO one byte per free cycle,
// word 0 first, least-significant byte first.
module debug_byte_serializer
  import debug_pkg::*;
#(
  parameter int SNAP_WORDS = 32,
  parameter int WORD_W     = 32
) (
  input  logic                         clock,
  input  logic                         resetGral,
  input  logic                         capture,
  input  logic                         active,
  input  logic [SNAP_WORDS*WORD_W-1:0] snap,
  input  logic [31:0]                  cycle_count,
  input  logic                         tx_full,
  output logic [7:0]                   tx_data,
  output logic                         tx_write,
  output logic                         done
);

  localparam int SHADOW_W = (SNAP_WORDS + 1) * WORD_W;
  localparam int BYTES    = SHADOW_W / 8;
  localparam int IDX_W    = $clog2(BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

  logic [SHADOW_W-1:0] shadow;
  logic [IDX_W-1:0]    idx;
  logic [7:0]          byte_sel;

  // Capture loads the shadow and rewinds the index; each accepted push advances it.
  always_ff @(posedge clock or negedge resetGral) begin
    if (!resetGral) begin
      shadow <= '0;
      idx    <= '0;
    end else if (capture) begin
      shadow <= {WORD_W'(cycle_count), snap};
      idx    <= '0;
    end else if (tx_write) begin
      idx <= done ? '0 : idx + IDX_W'(1);
    end
  end

  // A byte is pushed only while the FIFO has room; data reads 0 when idle.
  always_comb begin
    byte_sel = shadow[{idx, 3'b000} +: 8];
    tx_write = active && !tx_full;
    tx_data  = tx_write ? byte_sel : 8'h00;
    done     = tx_write && (idx == LAST_IDX);
  end

endmodule

// File: rtl/pipe_debug_ctrl.sv
// Pipeline debug controller: UART commands run, single-step or reset the
// pipeline; after run/step the pipeline state and cycle count are dumped.
// Handshakes: RX - uartRxRead pops the show-ahead head for one cycle and only
// while uartRxAvail=1; TX - a byte transfers in each cycle with
// uartTxWrite=1, which is raised only while uartTxFull=0.
module pipe_debug_ctrl
  import debug_pkg::*;
#(
  parameter int SNAP_WORDS = 32,
  parameter int WORD_W     = 32
) (
  input  logic                         clock,
  input  logic                         resetGral,
  input  logic [SNAP_WORDS*WORD_W-1:0] snapData,
  input  logic                         endOfProgram,
  input  logic [7:0]                   uartRxData,
  input  logic                         uartRxAvail,
  output logic                         uartRxRead,
  input  logic                         uartTxFull,
  output logic [7:0]                   uartTxData,
  output logic                         uartTxWrite,
  output logic                         pipeEnable,
  output logic                         pipeReset,
  output state_e                       debug_state
);

  if ((WORD_W % 8) != 0) begin : g_bad_word_w
    $error("pipe_debug_ctrl: WORD_W must be a multiple of 8");
  end
  if (SNAP_WORDS < 1) begin : g_bad_snap_words
    $error("pipe_debug_ctrl: SNAP_WORDS must be at least 1");
  end

  state_e      state;
  state_e      next_state;
  logic [31:0] cycle_count;
  logic        capture;
  logic        send_active;
  logic        send_done;

  // Next-state decode; the RX pop is combinational so the command is decoded
  // in the same cycle it leaves the FIFO.
  always_comb begin
    next_state  = state;
    uartRxRead  = 1'b0;
    capture     = 1'b0;
    send_active = 1'b0;
    case (state)
      ST_IDLE: begin
        if (uartRxAvail && resetGral) begin
          uartRxRead = 1'b1;
          case (uartRxData)
            CMD_RUN:    next_state = ST_RUN;
            CMD_STEP:   next_state = ST_STEP;
            CMD_PRESET: next_state = ST_PRESET;
            default:    next_state = ST_IDLE;
          endcase
        end
      end
      ST_RUN:     if (endOfProgram) next_state = ST_CAPTURE;
      ST_STEP:    next_state = ST_CAPTURE;
      ST_CAPTURE: begin
        capture    = 1'b1;
        next_state = ST_SEND;
      end
      ST_SEND: begin
        send_active = 1'b1;
        if (send_done) next_state = ST_IDLE;
      end
      ST_PRESET:  next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  // State register with registered pipeline controls derived from the next state.
  always_ff @(posedge clock or negedge resetGral) begin
    if (!resetGral) begin
      state      <= ST_IDLE;
      pipeEnable <= 1'b0;
      pipeReset  <= 1'b0;
    end else begin
      state      <= next_state;
      pipeEnable <= enables_pipe(next_state);
      pipeReset  <= (next_state == ST_PRESET);
    end
  end

  // Counts enabled pipeline cycles; cleared by a pipeline reset.
  always_ff @(posedge clock or negedge resetGral) begin
    if (!resetGral) begin
      cycle_count <= '0;
    end else if (state == ST_PRESET) begin
      cycle_count <= '0;
    end else if (pipeEnable) begin
      cycle_count <= cycle_count + 32'd1;
    end
  end

  assign debug_state = state;

  debug_byte_serializer #(
    .SNAP_WORDS(SNAP_WORDS),
    .WORD_W    (WORD_W)
  ) u_serializer (
    .clock      (clock),
    .resetGral  (resetGral),
    .capture    (capture),
    .active     (send_active),
    .snap       (snapData),
    .cycle_count(cycle_count),
    .tx_full    (uartTxFull),
    .tx_data    (uartTxData),
    .tx_write   (uartTxWrite),
    .done       (send_done)
  );

endmodule

// File: tb/tb_pipe_debug_ctrl.sv
// Bench for pipe_debug_ctrl: RX FIFO and TX FIFO models, a command-level
// reference model and a byte scoreboard.
module tb_pipe_debug_ctrl;
  import debug_pkg::*;

  localparam int SNAP_WORDS = 2;
  localparam int WORD_W     = 32;
  localparam int NBYTES     = (SNAP_WORDS + 1) * WORD_W / 8;

  logic                         clock = 1'b0;
  logic                         resetGral = 1'b0;
  logic [SNAP_WORDS*WORD_W-1:0] snapData = '0;
  logic                         endOfProgram = 1'b0;
  logic [7:0]                   uartRxData = 8'h00;
  logic                         uartRxAvail = 1'b0;
  logic                         uartRxRead;
  logic                         uartTxFull = 1'b0;
  logic [7:0]                   uartTxData;
  logic                         uartTxWrite;
  logic                         pipeEnable;
  logic                         pipeReset;
  state_e                       debug_state;

  // clock / reset block
  always #5 clock = ~clock;

  pipe_debug_ctrl #(.SNAP_WORDS(SNAP_WORDS), .WORD_W(WORD_W)) dut (
    .clock       (clock),
    .resetGral   (resetGral),
    .snapData    (snapData),
    .endOfProgram(endOfProgram),
    .uartRxData  (uartRxData),
    .uartRxAvail (uartRxAvail),
    .uartRxRead  (uartRxRead),
    .uartTxFull  (uartTxFull),
    .uartTxData  (uartTxData),
    .uartTxWrite (uartTxWrite),
    .pipeEnable  (pipeEnable),
    .pipeReset   (pipeReset),
    .debug_state (debug_state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  rx_q[$];
  logic [7:0]  got_q[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  cmd_q[$];
  logic [31:0] model_cnt = 0;

  int en_cnt, prst_cnt, rd_cnt, bad_write, bad_read, run_en;
  int eop_after = -1;
  int full_hold = 0;
  int hold_at   = -1;
  bit pop_pending = 0;
  bit rand_full   = 0;
  bit scramble    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver: applies FIFO pops and new stimulus just after the active edge
  task automatic update_inputs();
    logic [7:0] tmp;
    if (pop_pending) begin
      if (rx_q.size() > 0) tmp = rx_q.pop_front();
      pop_pending = 0;
    end
    uartRxAvail = (rx_q.size() > 0);
    uartRxData  = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
    if (hold_at >= 0 && got_q.size() == hold_at) begin
      full_hold = 5;
      hold_at   = -1;
    end
    if (full_hold > 0) begin
      uartTxFull = 1'b1;
      full_hold--;
    end else begin
      uartTxFull = rand_full ? ($urandom_range(0, 3) == 0) : 1'b0;
    end
    if (eop_after >= 0) endOfProgram = (run_en >= eop_after);
    if (scramble && got_q.size() > 0) snapData = {$urandom, $urandom};
  endtask

  // monitor: samples outputs mid-cycle
  task automatic sample();
    if (pipeEnable) begin
      en_cnt++;
      run_en++;
    end
    if (pipeReset) prst_cnt++;
    if (uartRxRead) begin
      rd_cnt++;
      if (rx_q.size() == 0) bad_read++;
      pop_pending = 1;
    end
    if (uartTxWrite) begin
      if (uartTxFull) bad_write++;
      got_q.push_back(uartTxData);
    end
  endtask

  task automatic cycle();
    @(negedge clock);
    sample();
    @(posedge clock);
    #1;
    update_inputs();
  endtask

  task automatic clear_counts();
    got_q.delete();
    exp_q.delete();
    en_cnt = 0; prst_cnt = 0; rd_cnt = 0; bad_write = 0; bad_read = 0; run_en = 0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_pe"},    32'(pipeEnable),  32'd0);
    check({tag, "_prst"},  32'(pipeReset),   32'd0);
    check({tag, "_rd"},    32'(uartRxRead),  32'd0);
    check({tag, "_wr"},    32'(uartTxWrite), 32'd0);
    check({tag, "_data"},  32'(uartTxData),  32'd0);
    check({tag, "_state"}, 32'(debug_state), 32'(ST_IDLE));
  endtask

  // reference model: a dump is the snapshot words LSB-first, then the counter
  task automatic push_dump(input logic [SNAP_WORDS*WORD_W-1:0] snap, input logic [31:0] cnt);
    logic [31:0] w;
    for (int k = 0; k <= SNAP_WORDS; k++) begin
      w = (k < SNAP_WORDS) ? snap[k*WORD_W +: WORD_W] : cnt;
      for (int b = 0; b < 4; b++) exp_q.push_back(w[b*8 +: 8]);
    end
  endtask

  task automatic apply_reset();
    #2;
    resetGral = 1'b0;
    #1;
    check_outputs_zero("in_reset");
    repeat (2) @(posedge clock);
    #1;
    resetGral   = 1'b1;
    pop_pending = 0;
    full_hold   = 0;
    model_cnt   = 0;
    update_inputs();
  endtask

  // runs the commands in cmd_q (at most one 'c') and scoreboards the result
  task automatic run_txn(input string tag, input int n_run, input logic [63:0] snap,
                         input bit rfull, input bit scr, input int hold);
    int exp_en   = 0;
    int exp_prst = 0;
    int budget   = 800;
    bit has_run  = 0;
    clear_counts();
    snapData  = snap;
    rand_full = rfull;
    scramble  = scr;
    hold_at   = hold;
    foreach (cmd_q[i]) begin
      case (cmd_q[i])
        CMD_STEP: begin
          model_cnt += 1;
          exp_en    += 1;
          push_dump(snap, model_cnt);
        end
        CMD_RUN: begin
          model_cnt += 32'(n_run + 1);
          exp_en    += n_run + 1;
          has_run    = 1;
          push_dump(snap, model_cnt);
        end
        CMD_PRESET: begin
          model_cnt = 0;
          exp_prst++;
        end
        default: ;
      endcase
      rx_q.push_back(cmd_q[i]);
    end
    if (has_run) eop_after = n_run;
    else begin
      eop_after    = -1;
      endOfProgram = 1'($urandom_range(0, 1));
    end
    update_inputs();
    while (budget > 0 && (rx_q.size() > 0 || got_q.size() < exp_q.size())) begin
      cycle();
      budget--;
    end
    repeat (6) cycle();
    check({tag, "_timeout"}, 32'(budget > 0), 32'd1);
    check({tag, "_nbytes"}, got_q.size(), exp_q.size());
    foreach (exp_q[i])
      check($sformatf("%s_byte%0d", tag, i), (i < got_q.size()) ? 32'(got_q[i]) : 32'h100, 32'(exp_q[i]));
    check({tag, "_en_cycles"}, en_cnt, exp_en);
    check({tag, "_prst"}, prst_cnt, exp_prst);
    check({tag, "_pops"}, rd_cnt, cmd_q.size());
    check({tag, "_bad_rd"}, bad_read, 0);
    check({tag, "_wr_full"}, bad_write, 0);
    check({tag, "_end_state"}, 32'(debug_state), 32'(ST_IDLE));
    eop_after = -1;
    full_hold = 0;
    hold_at   = -1;
  endtask

  initial begin
    logic [7:0] junk;
    int budget;
    int held;

    // reset-value scenario
    #3;
    check_outputs_zero("por");
    @(posedge clock);
    #1;
    resetGral = 1'b1;
    clear_counts();
    update_inputs();
    repeat (20) cycle();
    check("idle_en", en_cnt, 0);
    check("idle_prst", prst_cnt, 0);
    check("idle_rd", rd_cnt, 0);
    check("idle_wr", got_q.size(), 0);
    #3;
    check_outputs_zero("idle");

    // single step with a known snapshot
    cmd_q = '{CMD_STEP};
    run_txn("step", 0, 64'h11223344_AABBCCDD, 0, 0, -1);

    // clear the counter, then run to EOP 10 cycles after entry
    cmd_q = '{CMD_PRESET};
    run_txn("preset", 0, 64'h0, 0, 0, -1);
    cmd_q = '{CMD_RUN};
    run_txn("run10", 10, {$urandom, $urandom}, 0, 0, -1);

    // TX backpressure for 5 cycles after byte 3
    cmd_q = '{CMD_STEP};
    run_txn("bp", 0, {$urandom, $urandom}, 0, 1, 3);

    // reset then step reports counter 1; unknown byte is dropped
    cmd_q = '{CMD_PRESET};
    run_txn("preset2", 0, 64'h0, 0, 0, -1);
    cmd_q = '{CMD_STEP};
    run_txn("step_after_r", 0, {$urandom, $urandom}, 0, 0, -1);
    cmd_q = '{8'h00};
    run_txn("unknown", 0, {$urandom, $urandom}, 0, 0, -1);

    // EOP already high on RUN entry
    cmd_q = '{CMD_RUN};
    run_txn("run0", 0, {$urandom, $urandom}, 1, 0, -1);

    // commands queued behind an active dump
    cmd_q = '{CMD_STEP, 8'h41, CMD_STEP};
    run_txn("queued", 0, {$urandom, $urandom}, 1, 0, -1);

    // reset in the middle of a dump
    clear_counts();
    snapData = {$urandom, $urandom};
    rx_q.push_back(CMD_STEP);
    update_inputs();
    budget = 200;
    while (budget > 0 && got_q.size() < 3) begin
      cycle();
      budget--;
    end
    check("mid_timeout", 32'(budget > 0), 32'd1);
    apply_reset();
    held = got_q.size();
    repeat (30) cycle();
    check("mid_no_more_bytes", got_q.size(), held);
    check("mid_en_after", en_cnt, 1);
    cmd_q = '{CMD_STEP};
    run_txn("after_mid", 0, {$urandom, $urandom}, 0, 0, -1);

    // randomized commands with random backpressure
    for (int t = 0; t < 14; t++) begin
      case ($urandom_range(0, 3))
        0: cmd_q = '{CMD_STEP};
        1: cmd_q = '{CMD_RUN};
        2: cmd_q = '{CMD_PRESET};
        default: begin
          junk = 8'($urandom_range(0, 255));
          if (junk == CMD_RUN || junk == CMD_STEP || junk == CMD_PRESET) junk = 8'h00;
          cmd_q = '{junk};
        end
      endcase
      run_txn($sformatf("rnd%0d", t), $urandom_range(0, 20), {$urandom, $urandom}, 1, 1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
